// File: rtl/clock_display_pkg.sv
// clock_display_pkg: shared constants and helpers
// for the HH:MM:SS seven-segment scan driver.
package clock_display_pkg;

  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_DASH  = 7'h40;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  localparam logic [2:0] DIG_S1  = 3'd0;
  localparam logic [2:0] DIG_S10 = 3'd1;
  localparam logic [2:0] DIG_M1  = 3'd2;
  localparam logic [2:0] DIG_M10 = 3'd3;
  localparam logic [2:0] DIG_H1  = 3'd4;
  localparam logic [2:0] DIG_H10 = 3'd5;

  localparam logic [5:0] SEC_MAX = 6'd59;
  localparam logic [5:0] MIN_MAX = 6'd59;
  localparam logic [4:0] HR_MAX  = 5'd23;

  typedef struct packed {
    logic [3:0] tens;
    logic [3:0] ones;
  } bcd_t;

  // Split 0..63 into tens/ones with a compare ladder.
  function automatic bcd_t to_bcd(input logic [5:0] v);
    bcd_t       r;
    logic [5:0] base;
    if (v >= 6'd60) begin
      r.tens = 4'd6; base = 6'd60;
    end else if (v >= 6'd50) begin
      r.tens = 4'd5; base = 6'd50;
    end else if (v >= 6'd40) begin
      r.tens = 4'd4; base = 6'd40;
    end else if (v >= 6'd30) begin
      r.tens = 4'd3; base = 6'd30;
    end else if (v >= 6'd20) begin
      r.tens = 4'd2; base = 6'd20;
    end else if (v >= 6'd10) begin
      r.tens = 4'd1; base = 6'd10;
    end else begin
      r.tens = 4'd0; base = 6'd0;
    end
    r.ones = 4'(v - base);
    return r;
  endfunction

endpackage

// File: rtl/clock_display_scan_seg7.sv
// seg7_encode: BCD digit to active-high
// segments, with dash and blank overrides.
module seg7_encode
  import clock_display_pkg::*;
(
  input  logic [3:0] bcd,
  input  logic       dash,
  input  logic       blank,
  output logic [6:0] seg
);

  // Dash wins over blank; both win over the digit.
  always_comb begin
    seg = SEG_BLANK;
    if (dash) begin
      seg = SEG_DASH;
    end else if (!blank) begin
      case (bcd)
        4'd0:    seg = SEG_0;
        4'd1:    seg = SEG_1;
        4'd2:    seg = SEG_2;
        4'd3:    seg = SEG_3;
        4'd4:    seg = SEG_4;
        4'd5:    seg = SEG_5;
        4'd6:    seg = SEG_6;
        4'd7:    seg = SEG_7;
        4'd8:    seg = SEG_8;
        4'd9:    seg = SEG_9;
        default: seg = SEG_BLANK;
      endcase
    end
  end

endmodule

// File: rtl/clock_display_scan.sv
// clock_display_scan: six-digit multiplexed
// HH:MM:SS driver with per-frame snapshot.
module clock_display_scan
  import clock_display_pkg::*;
#(
  parameter int SCAN_DIV = 1000,
  parameter bit BLANK_LZ = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] seconds,
  input  logic [5:0] minutes,
  input  logic [4:0] hours,
  output logic [6:0] seg,
  output logic       dp,
  output logic [5:0] dig_en
);

  localparam int PW =
    (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PW-1:0] PMAX =
    PW'(SCAN_DIV - 1);

  logic [PW-1:0] pre;
  logic [2:0]    idx;
  logic [5:0]    snap_s;
  logic [5:0]    snap_m;
  logic [4:0]    snap_h;
  logic          fresh;

  bcd_t bs;
  bcd_t bm;
  bcd_t bh;
  logic s_bad;
  logic m_bad;
  logic h_bad;

  logic [3:0] cur_bcd;
  logic       cur_dash;
  logic       cur_blank;
  logic [6:0] seg_nxt;
  logic       dp_nxt;
  logic [5:0] en_nxt;
  logic       last;

  assign bs = to_bcd(snap_s);
  assign bm = to_bcd(snap_m);
  assign bh = to_bcd({1'b0, snap_h});

  assign s_bad = snap_s > SEC_MAX;
  assign m_bad = snap_m > MIN_MAX;
  assign h_bad = snap_h > HR_MAX;

  assign last = pre == PMAX;

  // Pick the BCD digit and overrides for idx.
  always_comb begin
    cur_bcd   = 4'd0;
    cur_dash  = 1'b0;
    cur_blank = 1'b0;
    unique case (1'b1)
      idx == DIG_S1: begin
        cur_bcd  = bs.ones;
        cur_dash = s_bad;
      end
      idx == DIG_S10: begin
        cur_bcd  = bs.tens;
        cur_dash = s_bad;
      end
      idx == DIG_M1: begin
        cur_bcd  = bm.ones;
        cur_dash = m_bad;
      end
      idx == DIG_M10: begin
        cur_bcd  = bm.tens;
        cur_dash = m_bad;
      end
      idx == DIG_H1: begin
        cur_bcd  = bh.ones;
        cur_dash = h_bad;
      end
      idx == DIG_H10: begin
        cur_bcd   = bh.tens;
        cur_dash  = h_bad;
        cur_blank = BLANK_LZ &&
                    (bh.tens == 4'd0);
      end
      default: cur_blank = 1'b1;
    endcase
  end

  seg7_encode u_enc (
    .bcd   (cur_bcd),
    .dash  (cur_dash),
    .blank (cur_blank),
    .seg   (seg_nxt)
  );

  // Colon blinks on the minute/hour ones digits.
  always_comb begin
    dp_nxt = 1'b0;
    en_nxt = 6'b000001 << idx;
    if ((idx == DIG_M1) || (idx == DIG_H1))
      dp_nxt = !snap_s[0];
  end

  // Prescaler, digit index, snapshot and outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      pre    <= '0;
      idx    <= DIG_S1;
      snap_s <= '0;
      snap_m <= '0;
      snap_h <= '0;
      fresh  <= 1'b1;
      seg    <= SEG_BLANK;
      dp     <= 1'b0;
      dig_en <= '0;
    end else if (fresh) begin
      snap_s <= seconds;
      snap_m <= minutes;
      snap_h <= hours;
      fresh  <= 1'b0;
    end else begin
      seg    <= seg_nxt;
      dp     <= dp_nxt;
      dig_en <= en_nxt;
      if (last) begin
        pre <= '0;
        if (idx == DIG_H10) begin
          idx    <= DIG_S1;
          snap_s <= seconds;
          snap_m <= minutes;
          snap_h <= hours;
        end else begin
          idx <= idx + 3'd1;
        end
      end else begin
        pre <= pre + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_clock_display_scan.sv
// tb_clock_display_scan: directed frame checks
// with SCAN_DIV=4, both leading-zero settings.
module tb_clock_display_scan;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [5:0] seconds = '0;
  logic [5:0] minutes = '0;
  logic [4:0] hours = '0;

  logic [6:0] seg;
  logic       dp;
  logic [5:0] dig_en;
  logic [6:0] seg0;
  logic       dp0;
  logic [5:0] dig_en0;

  int errs = 0;
  int chks = 0;

  always #5 clk = ~clk;

  clock_display_scan #(
    .SCAN_DIV (4),
    .BLANK_LZ (1'b1)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .seconds (seconds),
    .minutes (minutes),
    .hours   (hours),
    .seg     (seg),
    .dp      (dp),
    .dig_en  (dig_en)
  );

  clock_display_scan #(
    .SCAN_DIV (4),
    .BLANK_LZ (1'b0)
  ) dut0 (
    .clk     (clk),
    .rst     (rst),
    .seconds (seconds),
    .minutes (minutes),
    .hours   (hours),
    .seg     (seg0),
    .dp      (dp0),
    .dig_en  (dig_en0)
  );

  task automatic chk(
    input string      tag,
    input logic [7:0] got,
    input logic [7:0] exp
  );
    chks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%h exp=%h",
               tag, got, exp);
    end
  endtask

  task automatic edge1();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".seg"}, {1'b0, seg}, 8'h00);
    chk({tag, ".dp"}, {7'b0, dp}, 8'h00);
    chk({tag, ".en"}, {2'b0, dig_en}, 8'h00);
    chk({tag, ".en0"}, {2'b0, dig_en0}, 8'h00);
  endtask

  // segs = {d5,...,d0}; h10n = digit 5 with
  // leading-zero blanking off. Inputs change
  // at the start of digit chg_d (-1: never).
  task automatic frame(
    input string       tag,
    input logic [41:0] segs,
    input logic [5:0]  dps,
    input logic [6:0]  h10n,
    input int          chg_d,
    input logic [4:0]  nh,
    input logic [5:0]  nm,
    input logic [5:0]  ns
  );
    logic [6:0] es;
    logic [6:0] es0;
    logic [5:0] ee;
    for (int d = 0; d < 6; d++) begin
      es  = segs[d*7 +: 7];
      es0 = (d == 5) ? h10n : es;
      ee  = 6'b000001 << d;
      for (int c = 0; c < 4; c++) begin
        edge1();
        chk($sformatf("%s.d%0d.seg", tag, d),
            {1'b0, seg}, {1'b0, es});
        chk($sformatf("%s.d%0d.en", tag, d),
            {2'b0, dig_en}, {2'b0, ee});
        chk($sformatf("%s.d%0d.dp", tag, d),
            {7'b0, dp}, {7'b0, dps[d]});
        chk($sformatf("%s.d%0d.seg0", tag, d),
            {1'b0, seg0}, {1'b0, es0});
        chk($sformatf("%s.d%0d.en0", tag, d),
            {2'b0, dig_en0}, {2'b0, ee});
        chk($sformatf("%s.d%0d.dp0", tag, d),
            {7'b0, dp0}, {7'b0, dps[d]});
        if (d == chg_d && c == 0) begin
          hours   = nh;
          minutes = nm;
          seconds = ns;
        end
      end
    end
  endtask

  initial begin
    hours   = 5'd12;
    minutes = 6'd34;
    seconds = 6'd56;
    rst     = 1'b1;
    edge1();
    chk_zero("reset");
    edge1();
    chk_zero("reset2");
    rst = 1'b0;
    edge1();
    chk_zero("blank");

    frame("f1_123456",
      {7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D},
      6'b010100, 7'h06, -1, 5'd0, 6'd0, 6'd0);
    frame("f2_123456",
      {7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D},
      6'b010100, 7'h06, 2, 5'd12, 6'd34, 6'd57);
    frame("f3_123457",
      {7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h07},
      6'b000000, 7'h06, 2, 5'd5, 6'd34, 6'd56);
    frame("f4_053456",
      {7'h00, 7'h6D, 7'h4F, 7'h66, 7'h6D, 7'h7D},
      6'b010100, 7'h3F, 1, 5'd0, 6'd34, 6'd60);
    frame("f5_003460",
      {7'h00, 7'h3F, 7'h4F, 7'h66, 7'h40, 7'h40},
      6'b010100, 7'h3F, 4, 5'd24, 6'd34, 6'd56);
    frame("f6_243456",
      {7'h40, 7'h40, 7'h4F, 7'h66, 7'h6D, 7'h7D},
      6'b010100, 7'h40, 0, 5'd12, 6'd59, 6'd59);
    frame("f7_125959",
      {7'h06, 7'h5B, 7'h6D, 7'h6F, 7'h6D, 7'h6F},
      6'b000000, 7'h06, 5, 5'd23, 6'd45, 6'd8);

    // Run into digit 3 of the 23:45:08 frame.
    repeat (13) edge1();
    chk("mid.en", {2'b0, dig_en}, 8'h08);
    chk("mid.seg", {1'b0, seg}, 8'h66);
    hours   = 5'd20;
    minutes = 6'd7;
    seconds = 6'd8;
    rst = 1'b1;
    edge1();
    chk_zero("midrst");
    rst = 1'b0;
    edge1();
    chk_zero("midblank");
    frame("f9_200708",
      {7'h5B, 7'h3F, 7'h3F, 7'h07, 7'h3F, 7'h7F},
      6'b010100, 7'h5B, -1, 5'd0, 6'd0, 6'd0);

    $display("Result: errors=%0d of %0d checks",
             errs, chks);
    $finish;
  end

endmodule

// File: doc/clock_display_scan.md
# clock_display_scan

Multiplexed six-digit seven-segment display driver that reads the binary time (seconds, minutes, hours) produced by the timekeeping counter and renders it as HH:MM:SS. Sits between the time counter and the board-level display pins. It takes a coherent snapshot of the time once per full scan so that a displayed frame never mixes two different times. It then scans one digit at a time at a programmable rate.

## Interface
- SCAN_DIV, 1000, clock cycles each digit is driven; legal range ≥ 2.
- BLANK_LZ, 1, when 1, blank the hour-tens digit if it is zero.

- clk  input  1  system clock.
- rst  input  1  reset. Synchronous, active-high.
- seconds  input  6  binary seconds. Legal range 0..59.
- minutes  input  6  binary minutes. Legal range 0..59.
- hours  input  5  binary hours. Legal range 0..23.
- seg  output  7  segment drive, active-high. bit0=a … bit6=g.
- dp  output  1  decimal point / separator, active-high.
- dig_en  output  6  one-hot digit enable, active-high. bit0 = seconds ones … bit5 = hours tens.

## Operation
- **State:**
  - prescaler pre, width $clog2(SCAN_DIV).
  - digit index idx, range 0..5.
  - snapshot registers snap_s, snap_m, snap_h.
  - flag fresh.
- **Reset** (rst high at an edge):
  - pre=0, idx=0, snap_*=0, fresh=1.
  - seg=0, dp=0, dig_en=0.
  - Reset asserted mid-scan takes effect at that edge, with no completion of the current digit.
- **First edge with rst low while fresh=1 (blank cycle):**
  - snap_* ← inputs; fresh ← 0.
  - pre, idx and the outputs hold their reset values.
- **Normal edges:**
  - pre increments.
  - When pre==SCAN_DIV-1: pre←0 and idx←(idx==5 ? 0 : idx+1).
  - When idx==5 and pre==SCAN_DIV-1, snap_* ← inputs. The new snapshot is first shown on digit 0 of the next scan.
  - Inputs outside the snapshot load are ignored.
- **Digit mapping:**

  | idx | field | digit |
  |---|---|---|
  | 0 | snap_s | ones |
  | 1 | snap_s | tens |
  | 2 | snap_m | ones |
  | 3 | snap_m | tens |
  | 4 | snap_h | ones |
  | 5 | snap_h | tens |

  - tens = value/10, ones = value%10.
  - Compute tens/ones by comparison or subtraction; no generic divider.
- **Segment codes (hex):**
  - Digits: 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F.
  - dash=40, blank=00.
- **Out of range:**
  - snap_s>59 or snap_m>59 or snap_h>23 → both digits of that field show dash.
  - Other fields are unaffected.
- **Leading zero:**
  - When BLANK_LZ=1 and the hour-tens digit is 0 (hours 0..9), seg=00 on idx 5.
  - dig_en is still asserted.
- **Separator:**
  - dp=1 on idx 2 and idx 4 when snap_s[0]==0; otherwise dp=0.
  - This gives a 1 Hz colon blink when seconds advance at 1 Hz.
  - dp=0 on all other digits.
  - dp on idx 2/4 while the seconds field is out of range still follows snap_s[0].

## Timing
- seg, dp and dig_en are registered. At each normal edge they are loaded from the pre-edge idx and snap_*.
- Exactly one dig_en bit is high at all times, except during reset and the blank cycle (all zero).
- After rst deasserts:
  - Edge 1 is the blank cycle.
  - Edge 2 drives digit 0 (dig_en=000001).
  - Each digit is driven for exactly SCAN_DIV cycles.
  - A full frame is 6·SCAN_DIV cycles.
- Snapshot-to-display latency: a value sampled at the idx 5→0 edge appears on digit 0 one edge later.
- No handshake: inputs are sampled blindly and must be stable in clk domain (same clock as the time counter).

## Structure
- **Package clock_display_pkg:**
  - segment code constants SEG_0..SEG_9, SEG_DASH, SEG_BLANK;
  - digit index constants DIG_S1..DIG_H10;
  - field limits 59/23.
- **Sub-module seg7_encode:** combinational, 4-bit BCD plus dash/blank selects → 7-bit seg.
- Everything else (prescaler, index, snapshot, split, output registers) stays in clock_display_scan.

## Test plan
All scenarios use SCAN_DIV=4.
1. **Reset then basic scan.** Reset with inputs 12:34:56 → edge 1 all outputs 0. From edge 2, digits 0..5 in sequence, 4 cycles each: seg 7D,6D,66,4F,5B,06 with dig_en 000001…100000. Frame repeats every 24 cycles.
2. **Snapshot coherency.** Change seconds 56→57 while idx=2 → idx 3..5 of that frame still from 56. Next frame digit 0 = 07.
3. **Leading zero.** hours=5, BLANK_LZ=1 → idx 5: dig_en=100000, seg=00. With BLANK_LZ=0 → seg=3F. With hours=0 and BLANK_LZ=1 → idx 4 seg=3F, idx 5 seg=00.
4. **Out of range.** seconds=60 → idx 0,1 seg=40, other digits normal. hours=24 → idx 4,5 seg=40.
5. **Separator.** seconds=56 → dp=1 only while dig_en is 000100 or 010000. seconds=57 → dp=0 throughout the frame.
6. **Reset mid-scan.** Assert rst for one cycle at idx=3 → next edge all outputs 0, then one blank cycle, then restart at digit 0 with a fresh snapshot.
